// File: rtl/pong_anim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_anim_pkg
// Description : Shared mode encodings and state type for the Pong LED
//               animator.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_anim_pkg;

  // Controller mode encodings, sampled together with the start strobe
  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_PAUSE = 2'b01;
  localparam logic [1:0] MODE_GOAL  = 2'b10;
  localparam logic [1:0] MODE_WIN   = 2'b11;

  // Animator states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PAUSE = 2'd1,
    S_GOAL  = 2'd2,
    S_WIN   = 2'd3
  } state_t;

endpackage : pong_anim_pkg
`default_nettype wire

// File: rtl/anim_step_timer.sv
`default_nettype none
// ============================================================================
// Module      : anim_step_timer
// Description : Step prescaler. Counts 0..DIV-1 and asserts tick on the
//               cycle whose edge wraps the count back to 0. Clear restarts
//               the count at 0 and suppresses the tick.
// Revision    : 1.0 - initial release
// ============================================================================
module anim_step_timer #(
  parameter int DIV = 1
) (
  input  logic BALL_CLOCK,
  input  logic RESET_N,
  input  logic clear,
  output logic tick
);

  // Counter is at least one bit wide so DIV=1 still has a legal register
  localparam int             CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  C_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == C_LAST);
  assign tick   = w_last && !clear;

  // Prescaler count, restarted by clear and wrapped at DIV-1
  always_ff @(posedge BALL_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt <= '0;
    end else if (clear || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule : anim_step_timer
`default_nettype wire

// File: rtl/led_animator.sv
`default_nettype none
// ============================================================================
// Module      : led_animator
// Description : N-LED status animator for Pong. Plays goal chase, win
//               burst and pause patterns on a start strobe, with busy/done
//               status, a repeat count and a step prescaler.
//               Optional macro LED_ANIM_PAUSE_BLINK_EN makes PAUSE blink
//               (all ones / all zeros every 8 step ticks).
// Revision    : 1.0 - initial release
// ============================================================================
module led_animator
  import pong_anim_pkg::*;
#(
  parameter int N_LEDS  = 8,
  parameter int REPEATS = 3,
  parameter int DIV     = 1
) (
  input  logic              BALL_CLOCK,
  input  logic              RESET_N,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              side,
  output logic [N_LEDS-1:0] led,
  output logic              busy,
  output logic              done
);

  localparam int                HALF        = N_LEDS / 2;
  localparam int                PW          = $clog2(REPEATS + 1);
  localparam logic [PW-1:0]     C_LAST_PASS = PW'(REPEATS - 1);
  localparam logic [N_LEDS-1:0] C_LSB       = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] C_MSB       = C_LSB << (N_LEDS - 1);
  localparam logic [N_LEDS-1:0] C_CENTRE    = (C_LSB << (HALF - 1)) | (C_LSB << HALF);

  state_t            r_state;
  logic [N_LEDS-1:0] r_led;
  logic              r_busy;
  logic              r_done;
  logic [PW-1:0]     r_pass;
  logic              r_side;
`ifdef LED_ANIM_PAUSE_BLINK_EN
  logic [2:0]        r_blink_cnt;
`endif

  logic              w_tick;
  logic [N_LEDS-1:0] w_goal_next;
  logic [N_LEDS-1:0] w_goal_start;
  logic              w_goal_end;
  logic [N_LEDS-1:0] w_win_next;
  logic              w_win_end;
  logic              w_last_pass;

  anim_step_timer #(
    .DIV (DIV)
  ) u_step_timer (
    .BALL_CLOCK (BALL_CLOCK),
    .RESET_N    (RESET_N),
    .clear      (start),
    .tick       (w_tick)
  );

  // Goal chase runs toward the far end selected by the latched side
  assign w_goal_next  = r_side ? (r_led >> 1) : (r_led << 1);
  assign w_goal_start = r_side ? C_MSB : C_LSB;
  assign w_goal_end   = r_side ? r_led[0] : r_led[N_LEDS-1];

  // Win pair: upper half moves up, lower half moves down
  assign w_win_next   = {r_led[N_LEDS-2:HALF], 1'b0, 1'b0, r_led[HALF-1:1]};
  assign w_win_end    = r_led[0];

  assign w_last_pass  = (r_pass == C_LAST_PASS);

  assign led  = r_led;
  assign busy = r_busy;
  assign done = r_done;

  // Animator FSM with registered LED, busy and done outputs
  always_ff @(posedge BALL_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_led       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= '0;
      r_side      <= 1'b0;
`ifdef LED_ANIM_PAUSE_BLINK_EN
      r_blink_cnt <= 3'd0;
`endif
    end else begin
      r_done <= 1'b0;
      if (start) begin
        // A start always wins, even over a completion tick in the same cycle
        r_pass      <= '0;
        r_side      <= side;
`ifdef LED_ANIM_PAUSE_BLINK_EN
        r_blink_cnt <= 3'd0;
`endif
        case (mode)
          MODE_PAUSE: begin
            r_state <= S_PAUSE;
            r_led   <= '1;
            r_busy  <= 1'b1;
          end
          MODE_GOAL: begin
            r_state <= S_GOAL;
            r_led   <= side ? C_MSB : C_LSB;
            r_busy  <= 1'b1;
          end
          MODE_WIN: begin
            r_state <= S_WIN;
            r_led   <= C_CENTRE;
            r_busy  <= 1'b1;
          end
          default: begin
            r_state <= S_IDLE;
            r_led   <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end else if (w_tick) begin
        case (r_state)
          S_GOAL: begin
            if (!w_goal_end) begin
              r_led <= w_goal_next;
            end else if (w_last_pass) begin
              r_state <= S_IDLE;
              r_led   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= '0;
            end else begin
              r_led  <= w_goal_start;
              r_pass <= r_pass + 1'b1;
            end
          end
          S_WIN: begin
            if (!w_win_end) begin
              r_led <= w_win_next;
            end else if (w_last_pass) begin
              r_state <= S_IDLE;
              r_led   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= '0;
            end else begin
              r_led  <= C_CENTRE;
              r_pass <= r_pass + 1'b1;
            end
          end
          S_PAUSE: begin
`ifdef LED_ANIM_PAUSE_BLINK_EN
            // Toggle the whole bar after every eighth step tick
            if (r_blink_cnt == 3'd7) begin
              r_led       <= ~r_led;
              r_blink_cnt <= 3'd0;
            end else begin
              r_blink_cnt <= r_blink_cnt + 3'd1;
            end
`else
            r_led <= '1;
`endif
          end
          default: begin
            r_led  <= '0;
            r_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule : led_animator
`default_nettype wire

// File: doc/led_animator.md
Name: led_animator

Overview:
Parametrised successor to the 8-LED Pong status animator. It drives an N-LED bar with goal, win and pause patterns. Adds an explicit start strobe, busy/done status, a configurable repeat count, and a step prescaler. Goal direction selects which player scored. Sits between the game controller (mode/start/side) and the board LED pins, clocked by BALL_CLOCK.

Parameters:
N_LEDS, 8, LED bar width; even, >= 4
REPEATS, 3, full pattern passes per goal/win animation; >= 1
DIV, 1, BALL_CLOCK cycles per animation step; >= 1

Ports:
BALL_CLOCK  in  1  sole clock; all state updates on rising edge
RESET_N  in  1  asynchronous, active-low reset
start  in  1  one-cycle strobe; samples mode and side
mode  in  2  00 idle, 01 pause, 10 goal, 11 win
side  in  1  goal direction: 0 = LSB->MSB chase, 1 = MSB->LSB chase
led  out  N_LEDS  LED drive, registered
busy  out  1  high while in GOAL, WIN or PAUSE
done  out  1  one-cycle pulse when GOAL/WIN completes

Behaviour:
- Reset (async, RESET_N=0): state IDLE, led=0, busy=0, done=0, pass and prescaler counters cleared. This applies at any time, including mid-animation.
- mode and side are latched only when start=1; changes at other times are ignored.
- States:
  - IDLE: led=0, busy=0.
  - PAUSE: led=all ones, busy=1. Runs indefinitely; the only exit is a new start.
  - GOAL and WIN: animated, busy=1.
- start (any state) restarts the block immediately:
  - Prescaler=0, pass=0.
  - The first pattern appears on led at the edge that samples start, i.e. 1-cycle latency.
  - start with mode=00 goes to IDLE: led=0, no done pulse.
- Step tick: the prescaler counts 0..DIV-1 and ticks on the DIV-1 -> 0 wrap. Each pattern is held DIV cycles.
- GOAL:
  - One-hot pattern starting at bit 0 (side=0) or bit N_LEDS-1 (side=1).
  - Each tick shifts one position toward the far end.
  - Tick at the far end: wrap to the start bit and pass++.
  - Pass length is N_LEDS steps.
- WIN:
  - Starts with bits N_LEDS/2-1 and N_LEDS/2 set (two-hot).
  - Each tick moves the pair outward one position each.
  - Tick at pair {0, N_LEDS-1}: return to centre and pass++.
  - Pass length is N_LEDS/2 steps.
- Completion: on the tick that would start pass number REPEATS:
  - led=0, busy=0, state IDLE, done=1 for exactly one cycle.
  - Total display time: REPEATS*N_LEDS*DIV cycles for GOAL, REPEATS*(N_LEDS/2)*DIV cycles for WIN.
- Simultaneous start and completion tick: start wins, done stays 0 and the new animation begins.
- Counter widths: pass counter is $clog2(REPEATS+1) bits; prescaler is $clog2(DIV) bits, minimum 1. Neither counter wraps past its limit.

Optional Feature:
Macro: LED_ANIM_PAUSE_BLINK_EN
- Defined: PAUSE toggles led between all ones and all zeros every 8 step ticks, starting with all ones. busy stays 1 throughout.
- Undefined: PAUSE holds all ones, and no blink logic is synthesised.

Decomposition:
- Package pong_anim_pkg holds:
  - mode constants: MODE_IDLE=2'b00, MODE_PAUSE=2'b01, MODE_GOAL=2'b10, MODE_WIN=2'b11;
  - the state enum {S_IDLE, S_PAUSE, S_GOAL, S_WIN}.
- Sub-module anim_step_timer: parameter DIV; inputs BALL_CLOCK, RESET_N, clear; output tick. It wraps the prescaler.
- Pattern generation and the FSM stay in led_animator.

Test Plan:
- Goal, side=0 (N=8, REPEATS=3, DIV=1): start, mode=10.
  - led = 01,02,04,...,80 repeated 3 times (24 cycles).
  - Then led=00 and busy=0, with done high for exactly 1 cycle.
- Goal, side=1, DIV=2: led = 80,80,40,40,...,01,01 per pass; done arrives 48 cycles after start.
- Win (N=8, REPEATS=3, DIV=1): led = 18,24,42,81 x3, then 00 with done=1 on cycle 13 after start.
- Pause: start mode=01 gives led=FF and busy=1 for 100 cycles with done never asserted. Then start mode=00 gives led=00 and busy=0 next cycle, with no done.
- Restart and reset mid-animation:
  - start mode=11 during goal step 5: WIN begins next edge (led=18), pass count restarts.
  - RESET_N=0 mid-win: led=00 and busy=0 asynchronously.
- Collision and blink:
  - start asserted on the completion tick: done stays 0 and the new pattern appears.
  - With LED_ANIM_PAUSE_BLINK_EN and DIV=1: pause led = FF for 8 cycles, then 00 for 8, repeating.
